// File: rtl/coin_lane_scheduler.sv
// coin_lane_scheduler: spawns falling coins per lane, judges button hits/misses, tracks score/combo/lives; define COIN_SCHED_EARLY_PENALTY_EN to make early presses count as misses
module coin_lane_scheduler #(
  parameter int          NUM_LANES       = 3,
  parameter int          SPAWN_INTERVAL  = 30,
  parameter int          COOLDOWN_FRAMES = 8,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int          LIVES           = 3,
  parameter int          SCORE_W         = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_v_sync,
  input  logic                 i_start,
  input  logic [NUM_LANES-1:0] i_btn,
  input  logic [NUM_LANES-1:0] i_in_position,
  output logic [NUM_LANES-1:0] o_active,
  output logic [SCORE_W-1:0]   o_score,
  output logic [7:0]           o_combo,
  output logic [1:0]           o_lives,
  output logic                 o_game_over,
  output logic [NUM_LANES-1:0] o_hit,
  output logic [NUM_LANES-1:0] o_miss
);
  typedef enum logic [1:0] {G_IDLE, G_PLAY, G_OVER} g_state_t;
  typedef enum logic [1:0] {L_IDLE, L_FALL, L_READY, L_COOL} l_state_t;
  g_state_t             g_q, g_d;
  l_state_t             lane_q [NUM_LANES];
  l_state_t             lane_d [NUM_LANES];
  logic [7:0]           cool_q [NUM_LANES];
  logic [7:0]           cool_d [NUM_LANES];
  logic [2:0]           vs_q, vs_d;
  logic                 tick_q, tick_d;
  logic [15:0]          fc_q, fc_d, lfsr_q, lfsr_d;
  logic [NUM_LANES-1:0] btn_q, pos_q, hit_q, hit_d, miss_q, miss_d, active_q, active_d;
  logic [NUM_LANES-1:0] btn_edge, pos_fall;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [7:0]           combo_q, combo_d;
  logic [1:0]           lives_q, lives_d;
  logic                 game_over_q, game_over_d;
  logic                 start_play, wrap, run;
  logic [1:0]           cand;
  logic [2:0]           n_hit, n_miss, pts;
  logic [4:0]           gain;
  logic [SCORE_W+4:0]   score_sum;
  logic [8:0]           combo_sum;

  assign btn_edge = i_btn & ~btn_q;
  assign pos_fall = pos_q & ~i_in_position;
  assign cand     = lfsr_d[1:0];

  // frame tick extraction, game state and spawn timing
  always_comb begin
    vs_d        = {vs_q[1:0], i_v_sync};
    tick_d      = vs_q[1] & ~vs_q[2];
    start_play  = g_q == G_IDLE && i_start;
    g_d         = start_play ? G_PLAY :
                  (g_q == G_PLAY && lives_q == 2'd0) ? G_OVER :
                  (g_q == G_OVER && i_start) ? G_IDLE : g_q;
    run         = g_q == G_PLAY && g_d == G_PLAY;
    wrap        = run && tick_q && fc_q == 16'(SPAWN_INTERVAL - 1);
    fc_d        = (start_play || wrap) ? 16'd0 : (run && tick_q) ? fc_q + 16'd1 : fc_q;
    lfsr_d      = start_play ? LFSR_SEED :
                  wrap ? {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]} : lfsr_q;
    game_over_d = g_d == G_OVER;
  end

  // per-lane coin lifecycle and hit/miss judging
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_d[i] = lane_q[i];
      cool_d[i] = cool_q[i];
      hit_d[i]  = 1'b0;
      miss_d[i] = 1'b0;
      if (!run) begin
        lane_d[i] = L_IDLE;
        cool_d[i] = 8'd0;
      end else begin
        case (lane_q[i])
          L_IDLE: if (wrap && cand == 2'(i)) lane_d[i] = L_FALL;
          L_FALL: begin
`ifdef COIN_SCHED_EARLY_PENALTY_EN
            if (btn_edge[i]) begin
              miss_d[i] = 1'b1;
              lane_d[i] = L_COOL;
            end else
`endif
            if (i_in_position[i]) lane_d[i] = L_READY;
          end
          L_READY: begin
            if (btn_edge[i]) begin
              hit_d[i]  = 1'b1;
              lane_d[i] = L_COOL;
            end else if (pos_fall[i]) begin
              miss_d[i] = 1'b1;
              lane_d[i] = L_COOL;
            end
          end
          L_COOL: begin
            if (tick_q) begin
              lane_d[i] = cool_q[i] == 8'(COOLDOWN_FRAMES - 1) ? L_IDLE : L_COOL;
              cool_d[i] = cool_q[i] == 8'(COOLDOWN_FRAMES - 1) ? 8'd0 : cool_q[i] + 8'd1;
            end
          end
        endcase
      end
      active_d[i] = lane_d[i] == L_FALL || lane_d[i] == L_READY;
    end
  end

  // score, combo and lives from last clock's judged pulses; every hit uses the pre-update combo
  always_comb begin
    n_hit     = 3'($countones(hit_q));
    n_miss    = 3'($countones(miss_q));
    pts       = 3'd1 + ((combo_q[7:4] != 4'd0) ? 3'd3 : {1'b0, combo_q[3:2]});
    gain      = {2'b0, n_hit} * {2'b0, pts};
    score_sum = {5'd0, score_q} + (SCORE_W + 5)'(gain);
    combo_sum = {1'b0, combo_q} + {6'd0, n_hit};
    score_d   = start_play ? '0 : (|score_sum[SCORE_W+4:SCORE_W]) ? '1 : score_sum[SCORE_W-1:0];
    combo_d   = (start_play || |miss_q) ? 8'd0 : combo_sum[8] ? 8'hff : combo_sum[7:0];
    lives_d   = start_play ? 2'(LIVES) : ({1'b0, lives_q} > n_miss) ? lives_q - n_miss[1:0] : 2'd0;
  end

  // state registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vs_q        <= '0;
      tick_q      <= 1'b0;
      g_q         <= G_IDLE;
      fc_q        <= '0;
      lfsr_q      <= LFSR_SEED;
      btn_q       <= '0;
      pos_q       <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      active_q    <= '0;
      score_q     <= '0;
      combo_q     <= '0;
      lives_q     <= 2'(LIVES);
      game_over_q <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_q[i] <= L_IDLE;
        cool_q[i] <= 8'd0;
      end
    end else begin
      vs_q        <= vs_d;
      tick_q      <= tick_d;
      g_q         <= g_d;
      fc_q        <= fc_d;
      lfsr_q      <= lfsr_d;
      btn_q       <= i_btn;
      pos_q       <= i_in_position;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      active_q    <= active_d;
      score_q     <= score_d;
      combo_q     <= combo_d;
      lives_q     <= lives_d;
      game_over_q <= game_over_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_q[i] <= lane_d[i];
        cool_q[i] <= cool_d[i];
      end
    end
  end

  assign o_active    = active_q;
  assign o_score     = score_q;
  assign o_combo     = combo_q;
  assign o_lives     = lives_q;
  assign o_game_over = game_over_q;
  assign o_hit       = hit_q;
  assign o_miss      = miss_q;
endmodule

// File: tb/tb_coin_lane_scheduler.sv
// tb_coin_lane_scheduler: directed game scenarios checked against a behavioural lane/score model
module tb_coin_lane_scheduler;
  localparam int IDLE = 0, FALL = 1, READY = 2, COOL = 3;
`ifdef COIN_SCHED_EARLY_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  typedef struct {
    logic [2:0]  hit;
    logic [2:0]  miss;
    logic [15:0] score;
    logic [7:0]  combo;
    logic [1:0]  lives;
  } exp_t;
  logic        clk = 1'b0, rst = 1'b1, vs = 1'b0, start = 1'b0;
  logic [2:0]  btn = '0, pos = '0;
  logic [2:0]  o_active, o_hit, o_miss;
  logic [15:0] o_score;
  logic [7:0]  o_combo;
  logic [1:0]  o_lives;
  logic        o_game_over;
  int          total = 0, bad = 0;
  int          m_score, m_combo, m_lives, m_fc;
  logic [15:0] m_lfsr;
  int          m_st [3];
  int          m_cnt [3];
  bit          m_play;
  exp_t        sb [$];

  always #5 clk = ~clk;

  coin_lane_scheduler dut (
    .i_clk(clk), .i_rst(rst), .i_v_sync(vs), .i_start(start), .i_btn(btn),
    .i_in_position(pos), .o_active(o_active), .o_score(o_score), .o_combo(o_combo),
    .o_lives(o_lives), .o_game_over(o_game_over), .o_hit(o_hit), .o_miss(o_miss)
  );

  function automatic logic [2:0] st_mask(input int s);
    logic [2:0] m = '0;
    for (int i = 0; i < 3; i++) m[i] = (m_st[i] == s);
    return m;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_new_game();
    m_play = 1; m_fc = 0; m_lfsr = 16'hACE1;
    m_score = 0; m_combo = 0; m_lives = 3;
    for (int i = 0; i < 3; i++) begin m_st[i] = IDLE; m_cnt[i] = 0; end
  endtask

  task automatic do_tick();
    int sp = -1;
    int c;
    vs = 1'b1; cyc(4); vs = 1'b0; cyc(2);
    if (m_play) begin
      if (m_fc == 29) begin
        m_fc = 0;
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        c = int'(m_lfsr[1:0]);
        if (c < 3) if (m_st[c] == IDLE) sp = c;
      end else m_fc++;
      for (int i = 0; i < 3; i++) if (m_st[i] == COOL) begin
        m_cnt[i]++;
        if (m_cnt[i] == 8) begin m_st[i] = IDLE; m_cnt[i] = 0; end
      end
      if (sp >= 0) m_st[sp] = FALL;
    end
    chk("tick_active", o_active, st_mask(FALL) | st_mask(READY));
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask

  task automatic wait_spawn(output int lane);
    logic [2:0] had = st_mask(FALL);
    lane = -1;
    for (int k = 0; k < 1200 && lane < 0; k++) begin
      do_tick();
      for (int i = 0; i < 3; i++) if (m_st[i] == FALL && !had[i]) lane = i;
    end
    if (lane < 0) begin
      total++; bad++;
      $display("FAIL spawn_timeout observed=none expected=spawn");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  endtask

  task automatic make_ready(input logic [2:0] m);
    pos = pos | m;
    cyc(2);
    for (int i = 0; i < 3; i++) if (m[i] && m_st[i] == FALL) m_st[i] = READY;
  endtask

  task automatic judge(input string tag, input logic [2:0] b, input logic [2:0] d);
    exp_t e;
    logic [2:0] h = '0, ms = '0;
    int nh, nm, pts;
    for (int i = 0; i < 3; i++) begin
      h[i]  = b[i] && m_st[i] == READY;
      ms[i] = (m_st[i] == READY && !b[i] && d[i]) || (PEN && m_st[i] == FALL && b[i]);
      if (h[i] || ms[i]) begin m_st[i] = COOL; m_cnt[i] = 0; end
    end
    nh = $countones(h); nm = $countones(ms);
    pts = 1 + ((m_combo / 4) > 3 ? 3 : m_combo / 4);
    m_score = (m_score + nh * pts) > 65535 ? 65535 : m_score + nh * pts;
    m_combo = nm > 0 ? 0 : ((m_combo + nh) > 255 ? 255 : m_combo + nh);
    m_lives = m_lives > nm ? m_lives - nm : 0;
    e.hit = h; e.miss = ms; e.score = 16'(m_score); e.combo = 8'(m_combo); e.lives = 2'(m_lives);
    sb.push_back(e);
    btn = b; pos = pos & ~d;
    cyc(1);
    e = sb.pop_front();
    chk({tag, "_hit"}, o_hit, e.hit);
    chk({tag, "_miss"}, o_miss, e.miss);
    cyc(1);
    chk({tag, "_score"}, o_score, e.score);
    chk({tag, "_combo"}, o_combo, e.combo);
    chk({tag, "_lives"}, o_lives, e.lives);
    btn = '0; pos = pos & ~(h | ms);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b;
    m_play = 0;
    cyc(2);
    chk("rst_active", o_active, 0); chk("rst_score", o_score, 0); chk("rst_combo", o_combo, 0);
    chk("rst_lives", o_lives, 3); chk("rst_over", o_game_over, 0);
    chk("rst_hit", o_hit, 0); chk("rst_miss", o_miss, 0);
    rst = 1'b0; cyc(1);
    start = 1'b1; cyc(1); start = 1'b0;
    model_new_game();
    ticks(30);
    chk("first_spawn", o_active, 3'b001);
    chk("first_lives", o_lives, 3); chk("first_score", o_score, 0);
    ticks(21);
    make_ready(3'b001);
    judge("hit1", 3'b001, 3'b000);
    ticks(9);
    chk("respawn_after_cool", o_active[0], 1'b1);
    ticks(22);
    make_ready(3'b001);
    judge("hit2", 3'b001, 3'b000);
    ticks(8);
    chk("drop_during_cool", o_active, 3'b000);
    wait_spawn(a); make_ready(3'(1 << a)); judge("hit3", 3'(1 << a), 3'b000);
    wait_spawn(a); make_ready(3'(1 << a)); judge("hit4", 3'(1 << a), 3'b000);
    wait_spawn(a); make_ready(3'(1 << a)); judge("hit5_bonus", 3'(1 << a), 3'b000);
    start = 1'b1; cyc(1); start = 1'b0;
    chk("start_in_play_score", o_score, 16'(m_score));
    chk("start_in_play_over", o_game_over, 0);
    wait_spawn(a); make_ready(3'(1 << a)); judge("miss1", 3'b000, 3'(1 << a));
    wait_spawn(a); wait_spawn(b);
    make_ready(3'(1 << a) | 3'(1 << b));
    judge("dual_hit", 3'(1 << a) | 3'(1 << b), 3'b000);
    wait_spawn(a); wait_spawn(b);
    make_ready(3'(1 << a) | 3'(1 << b));
    judge("hit_and_miss", 3'(1 << a), 3'(1 << b));
    wait_spawn(a); wait_spawn(b);
    make_ready(3'(1 << a));
    judge("last_miss", 3'b000, 3'(1 << a));
    cyc(1);
    m_play = 0;
    for (int i = 0; i < 3; i++) begin m_st[i] = IDLE; m_cnt[i] = 0; end
    chk("over_flag", o_game_over, 1); chk("over_active", o_active, 0);
    start = 1'b1; cyc(1); start = 1'b0;
    chk("idle_over_flag", o_game_over, 0); chk("idle_score_held", o_score, 16'(m_score));
    start = 1'b1; cyc(1); start = 1'b0;
    model_new_game();
    chk("restart_score", o_score, 0); chk("restart_lives", o_lives, 3); chk("restart_combo", o_combo, 0);
    wait_spawn(a);
    judge("early_press", 3'(1 << a), 3'b000);
    chk("early_active", o_active[a], m_st[a] == FALL);
    if (m_st[a] == FALL) begin
      make_ready(3'(1 << a));
      judge("late_hit", 3'(1 << a), 3'b000);
    end
    wait_spawn(a);
    make_ready(3'(1 << a));
    rst = 1'b1; cyc(1);
    chk("mid_rst_active", o_active, 0); chk("mid_rst_score", o_score, 0); chk("mid_rst_combo", o_combo, 0);
    chk("mid_rst_lives", o_lives, 3); chk("mid_rst_over", o_game_over, 0);
    chk("mid_rst_hit", o_hit, 0); chk("mid_rst_miss", o_miss, 0);
    rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
